// File: rtl/button_debouncer_pkg.sv
// Shared constants and types for the push-button debouncer.
// Defaults target a 50 MHz board clock with a 1 ms debounce timebase.
package btn_pkg;

  localparam int unsigned CLK_HZ          = 32'd50_000_000;
  localparam int unsigned DIV_FACTOR_DEF  = 32'd25_000;
  localparam int unsigned DEBOUNCE_MS_DEF = 32'd5;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } db_state_e;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side bundle: raw button in, debounced level, press pulse and ms clock out.
interface button_debouncer_if;

  logic button;
  logic signal;
  logic press_pulse;
  logic clk_ms;

  modport master (output button, input signal, input press_pulse, input clk_ms);
  modport slave  (input button, output signal, output press_pulse, output clk_ms);

endinterface

// File: rtl/button_debouncer_ms_tick_gen.sv
// Divides clk down to a 50% duty millisecond clock and a one-cycle tick
// on each falling edge of that clock.
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned DIV_FACTOR = DIV_FACTOR_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic clk_ms,
  output logic ms_tick
);

  localparam int unsigned CW = (DIV_FACTOR > 32'd1) ? $clog2(DIV_FACTOR) : 32'd1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_FACTOR - 32'd1);

  generate
    if (DIV_FACTOR < 32'd2) begin : g_bad_div
      $error("ms_tick_gen: DIV_FACTOR must be at least 2");
    end
  endgenerate

  logic [CW-1:0] r_div_cnt;
  logic          r_clk_ms;
  logic          w_wrap;

  assign w_wrap = (r_div_cnt == CNT_MAX);

  // Half-period counter; each wrap toggles the ms clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_clk_ms  <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_clk_ms  <= ~r_clk_ms;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
      r_clk_ms  <= r_clk_ms;
    end
  end

  assign clk_ms  = r_clk_ms;
  assign ms_tick = w_wrap & r_clk_ms;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: 2-flop synchronizer, ms-tick qualified
// change counter, registered clean level and press pulse.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DIV_FACTOR  = DIV_FACTOR_DEF,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   bus
);

  localparam int unsigned DW = (DEBOUNCE_MS >= 32'd1) ? $clog2(DEBOUNCE_MS + 32'd1) : 32'd1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_MS);

  generate
    if (DEBOUNCE_MS < 32'd1) begin : g_bad_db
      $error("button_debouncer: DEBOUNCE_MS must be at least 1");
    end
  endgenerate

  logic          w_ms_tick;
  logic          w_clk_ms;
  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_db_cnt;
  logic          r_signal;
  logic          r_signal_q;
  logic          r_press_pulse;
  db_state_e     w_state;
  logic [DW-1:0] w_db_next;
  logic          w_signal_next;

  ms_tick_gen #(.DIV_FACTOR(DIV_FACTOR)) u_ms_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .clk_ms  (w_clk_ms),
    .ms_tick (w_ms_tick)
  );

  // Two-flop synchronizer for the asynchronous raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_state = (r_sync2 != r_signal) ? ST_CHANGING : ST_STABLE;

  // Any cycle back at the output level restarts qualification (glitch reject)
  always_comb begin
    w_db_next     = r_db_cnt;
    w_signal_next = r_signal;
    case (w_state)
      ST_STABLE: begin
        w_db_next = '0;
      end
      ST_CHANGING: begin
        if (w_ms_tick) begin
          if ((r_db_cnt + DW'(1)) == DB_MAX) begin
            w_db_next     = '0;
            w_signal_next = r_sync2;
          end else begin
            w_db_next = r_db_cnt + DW'(1);
          end
        end else begin
          w_db_next = r_db_cnt;
        end
      end
      default: begin
        w_db_next = '0;
      end
    endcase
  end

  // Debounce counter, clean level and delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt      <= '0;
      r_signal      <= 1'b0;
      r_signal_q    <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_db_cnt      <= w_db_next;
      r_signal      <= w_signal_next;
      r_signal_q    <= r_signal;
      r_press_pulse <= r_signal & ~r_signal_q;
    end
  end

  assign bus.signal      = r_signal;
  assign bus.press_pulse = r_press_pulse;
  assign bus.clk_ms      = w_clk_ms;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer with a shrunken ms timebase; a
// cycle-indexed reference model predicts every output each clock.
module tb_button_debouncer;

  localparam int unsigned DF = 50;
  localparam int unsigned DB = 5;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  button_debouncer_if bus ();

  button_debouncer #(.DIV_FACTOR(DF), .DEBOUNCE_MS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: n = rising edges since reset release; histories indexed by edge
  int unsigned n;
  bit          hist     [0:65535];
  bit          sig_hist [0:65535];
  bit          m_sig;
  int          m_run;

  function automatic bit f_bs(int unsigned e);
    return (e >= 3) ? hist[e-2] : 1'b0;
  endfunction

  function automatic bit f_tick(int unsigned e);
    return (e % (2 * DF)) == 0;
  endfunction

  function automatic bit f_next_sig(int unsigned e);
    if (f_bs(e) != m_sig && f_tick(e) && (m_run + 1) == DB) return f_bs(e);
    return m_sig;
  endfunction

  function automatic int f_next_run(int unsigned e);
    if (f_bs(e) == m_sig) return 0;
    if (!f_tick(e)) return m_run;
    return ((m_run + 1) == DB) ? 0 : m_run + 1;
  endfunction

  function automatic bit f_exp_pulse();
    if (n < 2) return 1'b0;
    return sig_hist[n-1] && !((n >= 3) ? sig_hist[n-2] : 1'b0);
  endfunction

  function automatic bit f_exp_clk_ms();
    return ((n / DF) % 2) == 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n     <= 0;
      m_sig <= 1'b0;
      m_run <= 0;
    end else begin
      n             <= n + 1;
      hist[n+1]     <= bus.button;
      sig_hist[n+1] <= f_next_sig(n + 1);
      m_sig         <= f_next_sig(n + 1);
      m_run         <= f_next_run(n + 1);
    end
  end

  task automatic test_reset;
    #5;
    n_cmp++;
    if ({bus.signal, bus.press_pulse, bus.clk_ms} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_hold: got sig/pulse/clk_ms=%b expected 000",
               {bus.signal, bus.press_pulse, bus.clk_ms});
    end
    #10 reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL reset_after n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
    end
  endtask

  task automatic test_divider;
    int  toggles;
    bit  prev;
    toggles = 0;
    prev    = bus.clk_ms;
    for (int c = 0; c < 4 * DF; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL divider n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      if (bus.clk_ms !== prev) toggles++;
      prev = bus.clk_ms;
    end
    n_cmp++;
    if (toggles != 4) begin
      n_bad++;
      $display("FAIL divider_toggles: got %0d expected 4", toggles);
    end
  endtask

  task automatic test_bounce;
    int pulses;
    int gap;
    int width;
    pulses = 0;
    for (int p = 0; p < 4; p++) begin
      gap   = $urandom_range(5, 20);
      width = $urandom_range(1, 3);
      for (int c = 0; c < gap + width; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
          n_bad++;
          $display("FAIL bounce n=%0d: got %b expected %b", n,
                   {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
        end
        if (bus.press_pulse) pulses++;
        bus.button = (c >= gap);
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.press_pulse) pulses++;
      bus.button = 1'b0;
    end
    n_cmp++;
    if (pulses != 0 || bus.signal !== 1'b0 || dut.r_db_cnt !== '0) begin
      n_bad++;
      $display("FAIL bounce_result: got pulses=%0d signal=%b db_cnt=%0d expected 0/0/0",
               pulses, bus.signal, dut.r_db_cnt);
    end
  endtask

  task automatic test_long_press;
    int rise_at;
    int fall_at;
    int pulses;
    int len;
    rise_at = -1;
    pulses  = 0;
    len     = 20 * DF + $urandom_range(0, DF - 1);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL long_press n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      if (bus.press_pulse) pulses++;
      if (bus.signal && rise_at < 0) rise_at = c;
      bus.button = 1'b1;
    end
    n_cmp++;
    if (rise_at < 8 * DF || rise_at > 10 * DF + 4 || pulses != 1) begin
      n_bad++;
      $display("FAIL long_press_accept: got rise_at=%0d pulses=%0d expected rise in [%0d,%0d] and 1 pulse",
               rise_at, pulses, 8 * DF, 10 * DF + 4);
    end
    fall_at = -1;
    pulses  = 0;
    for (int c = 0; c < 20 * DF; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL long_release n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      if (bus.press_pulse) pulses++;
      if (!bus.signal && fall_at < 0) fall_at = c;
      bus.button = 1'b0;
    end
    n_cmp++;
    if (fall_at < 8 * DF || fall_at > 10 * DF + 4 || pulses != 0) begin
      n_bad++;
      $display("FAIL long_release_accept: got fall_at=%0d pulses=%0d expected fall in [%0d,%0d] and 0 pulses",
               fall_at, pulses, 8 * DF, 10 * DF + 4);
    end
  endtask

  task automatic test_short_press;
    int pulses;
    int high_cycles;
    pulses      = 0;
    high_cycles = 0;
    for (int c = 0; c < 20 * DF; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL short_press n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      if (bus.press_pulse) pulses++;
      if (bus.signal) high_cycles++;
      bus.button = (c >= 2 * DF) && (c < 8 * DF);
    end
    n_cmp++;
    if (pulses != 0 || high_cycles != 0) begin
      n_bad++;
      $display("FAIL short_press_reject: got pulses=%0d high_cycles=%0d expected 0/0", pulses, high_cycles);
    end
  endtask

  task automatic test_reset_mid_press;
    int rise_n;
    rise_n = -1;
    for (int c = 0; c < 6 * DF; c++) begin
      @(negedge clk);
      bus.button = 1'b1;
    end
    #5 reset = 1'b0;
    #2;
    n_cmp++;
    if ({bus.signal, bus.press_pulse, bus.clk_ms} !== 3'b000) begin
      n_bad++;
      $display("FAIL midpress_reset: got %b expected 000", {bus.signal, bus.press_pulse, bus.clk_ms});
    end
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    for (int c = 0; c < 12 * DF; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL midpress_requal n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      if (bus.signal && rise_n < 0) rise_n = n;
    end
    n_cmp++;
    if (rise_n != 10 * DF) begin
      n_bad++;
      $display("FAIL midpress_rise_edge: got %0d expected %0d", rise_n, 10 * DF);
    end
    for (int c = 0; c < 12 * DF; c++) begin
      @(negedge clk);
      bus.button = 1'b0;
    end
  endtask

  task automatic test_random;
    int hold;
    bit lvl;
    hold = 0;
    lvl  = bus.button;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        lvl  = ~lvl;
        hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(DF, 14 * DF);
      end
      hold--;
      @(negedge clk);
      n_cmp++;
      if ({bus.signal, bus.press_pulse, bus.clk_ms} !== {m_sig, f_exp_pulse(), f_exp_clk_ms()}) begin
        n_bad++;
        $display("FAIL random n=%0d: got %b expected %b", n,
                 {bus.signal, bus.press_pulse, bus.clk_ms}, {m_sig, f_exp_pulse(), f_exp_clk_ms()});
      end
      bus.button = lvl;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    bus.button = 1'b0;
    test_reset();
    test_divider();
    test_bounce();
    test_long_press();
    test_short_press();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
